// File: rtl/chan_pkg.sv
// ---------------------------------------------------------------------------
// chan_pkg
//  Shared definitions for the channelizer front-end sequencer:
//   - state_t           : frame-control FSM encoding
//   - MIN_FFT_SIZE      : smallest fft_size the sequencer accepts
//   - is_legal_fft_size : power-of-two, MIN..2^(size_width-1) range check
// ---------------------------------------------------------------------------
package chan_pkg;

  localparam int unsigned MIN_FFT_SIZE = 8;

  typedef enum logic [1:0] {
    S_RUN,     // normal streaming, config requests accepted
    S_FINISH,  // size change pending, completing the current frame
    S_DRAIN,   // input stopped, waiting for all frames to leave the buffer
    S_APPLY    // single cycle: load the pending size, restart at phase 0
  } state_t;

  // A size is legal when it is a power of two and lies in
  // [min_size, 2^(size_width-1)], i.e. the phase counter can index it.
  function automatic logic is_legal_fft_size(input logic [31:0] size,
                                             input int unsigned size_width,
                                             input int unsigned min_size);
    logic [31:0] max_size;
    max_size = 32'd1 << (size_width - 1);
    return (size != '0) && ((size & (size - 32'd1)) == '0) &&
           (size >= min_size) && (size <= max_size);
  endfunction

endpackage

// File: rtl/chan_axis_reg.sv
// ---------------------------------------------------------------------------
// chan_axis_reg
//  Single-stage AXI-stream register slice, latency 1. The payload is held
//  stable while out_valid & ~out_ready.
//  Ports:
//   clk, sync_reset      clock, synchronous active-high reset
//   in_valid / in_data   upstream beat (in_valid must only be set when in_ready)
//   in_ready             register can take a beat this cycle
//   out_valid / out_data registered beat
//   out_ready            downstream ready
// ---------------------------------------------------------------------------
module chan_axis_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  assign in_ready = ~out_valid | out_ready;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      out_valid <= 1'b0;
      // NOTE: the payload is reset as well because its phase/tlast fields are
      // visible outputs with defined reset values, not just don't-care data.
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/chan_frame_ctrl.sv
// ---------------------------------------------------------------------------
// chan_frame_ctrl
//  Front-end sequencer for the M/2 channelizer circular buffer. Tags each
//  input sample with its commutator phase and frame tlast, and owns the
//  active fft_size. A new size is applied only once the current frame is
//  complete and every outstanding frame has drained, so no frame ever spans
//  two sizes.
//  Ports:
//   clk, sync_reset                   clock, synchronous active-high reset
//   cfg_tvalid/cfg_tdata/cfg_tready   fft_size change request
//   cfg_err                           1-cycle pulse: accepted request illegal
//   s_axis_*                          input sample stream
//   m_axis_*, phase                   tagged sample stream to the buffer
//   fft_size                          active size
//   frame_done                        pulse per frame leaving downstream
//   busy                              high while a size change is in progress
// ---------------------------------------------------------------------------
module chan_frame_ctrl #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned FFT_SIZE_WIDTH   = 12,
  parameter int unsigned DEFAULT_FFT_SIZE = 64,
  parameter int unsigned MIN_FFT_SIZE     = chan_pkg::MIN_FFT_SIZE,
  parameter int unsigned OUTST_WIDTH      = 3
) (
  input  logic                      clk,
  input  logic                      sync_reset,
  input  logic                      cfg_tvalid,
  input  logic [FFT_SIZE_WIDTH-1:0] cfg_tdata,
  output logic                      cfg_tready,
  output logic                      cfg_err,
  input  logic                      s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  output logic                      s_axis_tready,
  output logic                      m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [FFT_SIZE_WIDTH-2:0] phase,
  output logic [FFT_SIZE_WIDTH-1:0] fft_size,
  input  logic                      frame_done,
  output logic                      busy
);

  import chan_pkg::state_t;
  import chan_pkg::S_RUN;
  import chan_pkg::S_FINISH;
  import chan_pkg::S_DRAIN;
  import chan_pkg::S_APPLY;
  import chan_pkg::is_legal_fft_size;

  localparam int unsigned PHASE_WIDTH   = FFT_SIZE_WIDTH - 1;
  localparam int unsigned PAYLOAD_WIDTH = PHASE_WIDTH + 1 + DATA_WIDTH;

  state_t                    state, state_next;
  logic [PHASE_WIDTH-1:0]    phase_cnt;
  logic [FFT_SIZE_WIDTH-1:0] pending_size;
  logic [FFT_SIZE_WIDTH-1:0] size_m1;
  logic [PHASE_WIDTH-1:0]    last_phase;
  logic [OUTST_WIDTH-1:0]    outstanding;

  logic reg_in_ready;
  logic input_open;
  logic accept;
  logic wrap;
  logic cfg_accept;
  logic cfg_legal;
  logic outst_dec;

  logic [PAYLOAD_WIDTH-1:0] reg_in_data;
  logic [PAYLOAD_WIDTH-1:0] reg_out_data;

  // Largest size equals 2^PHASE_WIDTH, so size-1 always fits the phase width.
  assign size_m1    = fft_size - 1'b1;
  assign last_phase = size_m1[PHASE_WIDTH-1:0];

  assign input_open    = (state == S_RUN) || (state == S_FINISH);
  assign s_axis_tready = reg_in_ready & input_open & ~sync_reset;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign wrap          = accept & (phase_cnt == last_phase);

  // Only S_RUN takes requests, so at most one change is in flight.
  assign cfg_tready = (state == S_RUN) & ~sync_reset;
  assign cfg_accept = cfg_tvalid & cfg_tready;
  assign cfg_legal  = is_legal_fft_size(32'(cfg_tdata), FFT_SIZE_WIDTH, MIN_FFT_SIZE);

  // A stray frame_done with nothing outstanding is ignored.
  assign outst_dec = frame_done & (outstanding != '0);

  assign busy = (state != S_RUN);

  assign reg_in_data = {phase_cnt, wrap, s_axis_tdata};

  chan_axis_reg #(
    .WIDTH (PAYLOAD_WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .sync_reset (sync_reset),
    .in_valid   (accept),
    .in_data    (reg_in_data),
    .in_ready   (reg_in_ready),
    .out_valid  (m_axis_tvalid),
    .out_data   (reg_out_data),
    .out_ready  (m_axis_tready)
  );

  assign phase        = reg_out_data[PAYLOAD_WIDTH-1 -: PHASE_WIDTH];
  assign m_axis_tlast = reg_out_data[DATA_WIDTH];
  assign m_axis_tdata = reg_out_data[DATA_WIDTH-1:0];

  // Next-state logic.
  always_comb begin
    // NOTE: state_next gets a default before any branch so no path through
    // the block leaves it unassigned, which would infer a latch.
    state_next = state;
    unique case (state)
      S_RUN: begin
        if (cfg_accept && cfg_legal) begin
          // Drain immediately when no partial frame exists after this cycle:
          // either this cycle's sample closes the frame, or we sit idle at
          // phase 0.
          if (wrap || ((phase_cnt == '0) && !accept)) state_next = S_DRAIN;
          else                                         state_next = S_FINISH;
        end
      end
      S_FINISH: if (wrap) state_next = S_DRAIN;
      S_DRAIN:  if ((outstanding == '0) && !m_axis_tvalid) state_next = S_APPLY;
      S_APPLY:  state_next = S_RUN;
      default:  state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state        <= S_RUN;
      phase_cnt    <= '0;
      fft_size     <= FFT_SIZE_WIDTH'(DEFAULT_FFT_SIZE);
      pending_size <= FFT_SIZE_WIDTH'(DEFAULT_FFT_SIZE);
      outstanding  <= '0;
      cfg_err      <= 1'b0;
    end else begin
      state   <= state_next;
      cfg_err <= cfg_accept & ~cfg_legal;

      if (cfg_accept && cfg_legal) pending_size <= cfg_tdata;

      if (state == S_APPLY) begin
        fft_size  <= pending_size;
        phase_cnt <= '0;
      end else if (accept) begin
        phase_cnt <= wrap ? '0 : phase_cnt + 1'b1;
      end

      unique case ({wrap, outst_dec})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_reset) begin
      assert (!(wrap && !outst_dec && (outstanding == '1)))
        else $error("chan_frame_ctrl: outstanding frame counter overflow");
      assert (!(frame_done && (outstanding == '0)))
        else $error("chan_frame_ctrl: frame_done with no outstanding frame");
    end
  end

endmodule

// File: tb/tb_chan_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_chan_frame_ctrl
//  Directed bench for chan_frame_ctrl with default parameters (64-point
//  default size, 12-bit size field). Input data is a running counter, so the
//  expected phase/tlast/data of every output beat follows from the start
//  phase, the active size and the first data word of each stretch.
//  frame_done is returned 30 cycles after each tlast beat leaves.
// ---------------------------------------------------------------------------
module tb_chan_frame_ctrl;

  localparam int DW = 32;
  localparam int FW = 12;
  localparam int PW = 11;

  logic          clk = 1'b0;
  logic          sync_reset;
  logic          cfg_tvalid;
  logic [FW-1:0] cfg_tdata;
  logic          cfg_tready;
  logic          cfg_err;
  logic          s_axis_tvalid;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [PW-1:0] phase;
  logic [FW-1:0] fft_size;
  logic          frame_done;
  logic          busy;

  chan_frame_ctrl dut (
    .clk           (clk),
    .sync_reset    (sync_reset),
    .cfg_tvalid    (cfg_tvalid),
    .cfg_tdata     (cfg_tdata),
    .cfg_tready    (cfg_tready),
    .cfg_err       (cfg_err),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .phase         (phase),
    .fft_size      (fft_size),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] ph;
    logic          tl;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         out_q[$];
  int            fd_q[$];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  bit            fd_en    = 1'b1;
  bit            chk_hold = 1'b0;
  bit            last_acc;
  bit            last_cfg_acc;
  bit            prev_busy = 1'b0;
  logic [FW-1:0] prev_size = '0;
  logic [FW-1:0] size_before = '0;
  logic [FW-1:0] size_after  = '0;
  int            last_tlast_cyc = -1;
  int            apply_cyc      = -1;
  int            first_new_cyc  = -1;
  logic [DW-1:0] nd = 32'hA500_0000;
  logic [DW-1:0] d0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs are already set; sample handshakes #1 later,
  // cross the edge, land 1 time unit after it.
  task automatic tick();
    bit            hold;
    logic [PW-1:0] hp;
    logic          ht;
    logic [DW-1:0] hd;
    beat_t         b;
    frame_done = (fd_q.size() > 0) && (fd_q[0] == cyc);
    if (frame_done) void'(fd_q.pop_front());
    #1;
    if (prev_busy && !busy) begin
      apply_cyc   = cyc;
      size_before = prev_size;
      size_after  = fft_size;
    end
    prev_busy    = busy;
    prev_size    = fft_size;
    last_acc     = s_axis_tvalid && s_axis_tready;
    last_cfg_acc = cfg_tvalid && cfg_tready;
    if (last_acc && apply_cyc >= 0 && first_new_cyc < apply_cyc) first_new_cyc = cyc;
    if (m_axis_tvalid && m_axis_tready) begin
      b.ph = phase; b.tl = m_axis_tlast; b.d = m_axis_tdata;
      out_q.push_back(b);
      if (m_axis_tlast) begin
        last_tlast_cyc = cyc;
        if (fd_en) fd_q.push_back(cyc + 30);
      end
    end
    hold = chk_hold && m_axis_tvalid && !m_axis_tready;
    hp = phase; ht = m_axis_tlast; hd = m_axis_tdata;
    @(posedge clk);
    #1;
    cyc++;
    if (hold) begin
      check("hold_valid", 32'(m_axis_tvalid), 32'd1);
      check("hold_phase", 32'(phase), 32'(hp));
      check("hold_tlast", 32'(m_axis_tlast), 32'(ht));
      check("hold_data",  m_axis_tdata, hd);
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    cfg_tvalid    = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Push n samples; at loop iteration cfg_idx (if >= 0) raise a one-cycle
  // config request and check its immediate effect.
  task automatic send(input int n, input int cfg_idx, input logic [FW-1:0] cfg_val,
                      input logic exp_err, input bit rnd);
    int acc = 0;
    int it  = 0;
    chk_hold = rnd;
    while (acc < n) begin
      if (it > n * 4 + 200) begin
        check("send_budget", 32'(acc), 32'(n));
        break;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = nd;
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_tvalid    = (cfg_idx >= 0) && (it == cfg_idx);
      cfg_tdata     = cfg_val;
      tick();
      if (last_acc) begin
        nd = nd + 32'd1;
        acc++;
      end
      if (cfg_idx >= 0 && it == cfg_idx) begin
        cfg_tvalid = 1'b0;
        check("cfg_taken", 32'(last_cfg_acc), 32'd1);
        check("cfg_err_pulse", 32'(cfg_err), 32'(exp_err));
        check("cfg_busy", 32'(busy), 32'(!exp_err));
      end else if (cfg_idx >= 0 && it == cfg_idx + 1) begin
        check("cfg_err_clear", 32'(cfg_err), 32'd0);
      end
      it++;
    end
    s_axis_tvalid = 1'b0;
    cfg_tvalid    = 1'b0;
    chk_hold      = 1'b0;
  endtask

  task automatic verify(input string tag, input int pos, input int n, input int ph0,
                        input int size, input logic [DW-1:0] dstart);
    int p;
    for (int j = 0; j < n; j++) begin
      if (pos + j < out_q.size()) begin
        p = (ph0 + j) % size;
        check({tag, "_phase"}, 32'(out_q[pos+j].ph), 32'(p));
        check({tag, "_tlast"}, 32'(out_q[pos+j].tl), 32'(p == size - 1));
        check({tag, "_data"},  out_q[pos+j].d, dstart + 32'(j));
      end
    end
  endtask

  task automatic mark_reset();
    apply_cyc     = -1;
    first_new_cyc = -1;
    out_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sz;
    sync_reset    = 1'b1;
    cfg_tvalid    = 1'b0;
    cfg_tdata     = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    frame_done    = 1'b0;
    @(posedge clk);
    #1;
    tick();
    tick();
    // Reset state
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_tlast",  32'(m_axis_tlast),  32'd0);
    check("rst_phase",    32'(phase),         32'd0);
    check("rst_fft_size", 32'(fft_size),      32'd64);
    check("rst_cfg_tready", 32'(cfg_tready),  32'd0);
    check("rst_cfg_err",  32'(cfg_err),       32'd0);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_busy",     32'(busy),          32'd0);
    sync_reset = 1'b0;
    #1;
    check("run_s_tready",   32'(s_axis_tready), 32'd1);
    check("run_cfg_tready", 32'(cfg_tready),    32'd1);

    // 1: 200 samples, continuous ready, latency 1
    mark_reset();
    d0 = nd;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = nd;
    tick();
    check("t1_first_acc", 32'(last_acc), 32'd1);
    nd = nd + 32'd1;
    check("t1_lat_valid", 32'(m_axis_tvalid), 32'd1);
    check("t1_lat_data",  m_axis_tdata,       d0);
    check("t1_lat_phase", 32'(phase),         32'd0);
    send(199, -1, '0, 1'b0, 1'b0);
    idle(3);
    check("t1_count", 32'(out_q.size()), 32'd200);
    verify("t1", 0, 200, 0, 64, d0);
    idle(40);

    // 2: random downstream ready, phases continue from 8
    mark_reset();
    d0 = nd;
    send(150, -1, '0, 1'b0, 1'b1);
    idle(3);
    check("t2_count", 32'(out_q.size()), 32'd150);
    verify("t2", 0, 150, 8, 64, d0);
    idle(40);

    // 4: illegal sizes 100, 4, 4096 (truncates to 0) are rejected
    mark_reset();
    d0 = nd;
    send(10, 3, 12'd100, 1'b1, 1'b0);
    send(10, 3, 12'd4, 1'b1, 1'b0);
    sz = 4096;
    send(10, 3, sz[11:0], 1'b1, 1'b0);
    check("t4_fft_size", 32'(fft_size), 32'd64);
    check("t4_busy", 32'(busy), 32'd0);
    idle(3);
    check("t4_count", 32'(out_q.size()), 32'd30);
    verify("t4", 0, 30, 30, 64, d0);
    idle(5);

    // 5: request (same size) in the cycle phase 63 is accepted -> drain now
    mark_reset();
    d0 = nd;
    send(24, 3, 12'd64, 1'b0, 1'b0);
    idle(3);
    check("t5_count", 32'(out_q.size()), 32'd24);
    verify("t5", 0, 24, 60, 64, d0);
    check("t5_drain_gap", 32'(apply_cyc - last_tlast_cyc), 32'd33);
    check("t5_first_new", 32'(first_new_cyc), 32'(apply_cyc));
    check("t5_size", 32'(size_after), 32'd64);

    // 3: request 128 at phase 20 -> finish frame, drain, apply
    mark_reset();
    d0 = nd;
    send(84, 0, 12'd128, 1'b0, 1'b0);
    idle(3);
    check("t3_count", 32'(out_q.size()), 32'd84);
    verify("t3_old", 0, 44, 20, 64, d0);
    verify("t3_new", 44, 40, 0, 128, d0 + 32'd44);
    check("t3_drain_gap", 32'(apply_cyc - last_tlast_cyc), 32'd33);
    check("t3_first_new", 32'(first_new_cyc), 32'(apply_cyc));
    check("t3_size_before", 32'(size_before), 32'd64);
    check("t3_size_after",  32'(size_after),  32'd128);
    check("t3_fft_size", 32'(fft_size), 32'd128);
    idle(40);

    // 6: two frames outstanding, reset at phase 37
    fd_en = 1'b0;
    mark_reset();
    d0 = nd;
    send(253, -1, '0, 1'b0, 1'b0);
    check("t6_count", 32'(out_q.size()), 32'd252);
    check("t6_pre_phase", 32'(phase), 32'd36);
    verify("t6_pre", 0, 252, 40, 128, d0);
    sync_reset    = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = nd;
    tick();
    check("t6_rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("t6_rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t6_rst_phase",    32'(phase),         32'd0);
    check("t6_rst_fft_size", 32'(fft_size),      32'd64);
    check("t6_rst_busy",     32'(busy),          32'd0);
    tick();
    sync_reset    = 1'b0;
    s_axis_tvalid = 1'b0;
    fd_q.delete();
    fd_en = 1'b1;
    mark_reset();
    d0 = nd;
    send(70, 0, 12'd64, 1'b0, 1'b0);
    idle(3);
    check("t6_count_post", 32'(out_q.size()), 32'd70);
    verify("t6_post", 0, 64, 0, 64, d0);
    verify("t6_next", 64, 6, 0, 64, d0 + 32'd64);
    check("t6_drain_gap", 32'(apply_cyc - last_tlast_cyc), 32'd33);
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
